// File: rtl/fir_out_frame_buffer.sv
// Capture buffer for one FIR output frame: stores samples in RAM, tracks length/peak,
// then holds until released. Captured samples are read back through a registered port.
module fir_out_frame_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 2048,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_fir_tdata,
    input  logic                  s_axis_fir_tvalid,
    input  logic                  s_axis_fir_tlast,
    output logic                  s_axis_fir_tready,
    input  logic                  release_buf,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic                  len_err,
    output logic [DATA_WIDTH-1:0] peak_abs,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    localparam logic [ADDR_WIDTH:0]   LenMax = (ADDR_WIDTH+1)'(FRAME_LEN);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MaxPos = ~MinNeg;

    state_e                r_state;
    logic [ADDR_WIDTH:0]   r_wr_cnt;
    logic [ADDR_WIDTH:0]   r_frame_len;
    logic                  r_len_err;
    logic [DATA_WIDTH-1:0] r_peak;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_mem [FRAME_LEN];

    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_cnt_next;
    logic                  w_at_max;
    logic                  w_frame_end;
    logic                  w_len_bad;
    logic [DATA_WIDTH-1:0] w_abs;
    logic [DATA_WIDTH-1:0] w_peak_next;
    logic                  w_rd_in_range;

    assign w_accept    = s_axis_fir_tvalid && (r_state == StFill);
    assign w_cnt_next  = r_wr_cnt + 1'b1;
    assign w_at_max    = (w_cnt_next == LenMax);
    assign w_frame_end = w_accept && (s_axis_fir_tlast || w_at_max);
    // A frame is good only if tlast lands exactly on the last buffer slot.
    assign w_len_bad   = !(s_axis_fir_tlast && w_at_max);

    // |x| with the most negative code saturated so the result fits in DATA_WIDTH bits.
    always_comb begin
        w_abs = s_axis_fir_tdata;
        if (s_axis_fir_tdata == MinNeg) begin
            w_abs = MaxPos;
        end else if (s_axis_fir_tdata[DATA_WIDTH-1]) begin
            w_abs = -s_axis_fir_tdata;
        end
    end

    assign w_peak_next   = (w_abs > r_peak) ? w_abs : r_peak;
    assign w_rd_in_range = ({1'b0, rd_addr} < LenMax);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StFill;
            r_wr_cnt      <= '0;
            r_frame_len   <= '0;
            r_len_err     <= 1'b0;
            r_peak        <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            unique case (r_state)
                StFill: begin
                    if (w_accept) begin
                        r_wr_cnt <= w_cnt_next;
                        r_peak   <= w_peak_next;
                        if (w_frame_end) begin
                            r_frame_len   <= w_cnt_next;
                            r_len_err     <= w_len_bad;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_state       <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (release_buf) begin
                        r_state     <= StFill;
                        r_wr_cnt    <= '0;
                        r_frame_len <= '0;
                        r_peak      <= '0;
                        r_len_err   <= 1'b0;
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

    // RAM has no reset so captured data survives a reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_cnt[ADDR_WIDTH-1:0]] <= s_axis_fir_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_in_range ? r_mem[rd_addr] : '0;
            end
        end
    end

    assign s_axis_fir_tready = (r_state == StFill);
    assign rd_data           = r_rd_data;
    assign rd_valid          = r_rd_valid;
    assign frame_done        = r_frame_done;
    assign frame_len         = r_frame_len;
    assign len_err           = r_len_err;
    assign peak_abs          = r_peak;
    assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_fir_out_frame_buffer.sv
// Directed-plus-random bench for fir_out_frame_buffer, checked against a frame-level
// reference model (sample array, beat count, running max of magnitudes).
module tb_fir_out_frame_buffer;

    localparam int DW = 16;
    localparam int FL = 2048;
    localparam int AW = 11;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          release_buf;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_done;
    logic [AW:0]   frame_len;
    logic          len_err;
    logic [DW-1:0] peak_abs;
    logic [CW-1:0] frame_count;

    always #5 clk = ~clk;

    fir_out_frame_buffer #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_axis_fir_tdata (tdata),
        .s_axis_fir_tvalid(tvalid),
        .s_axis_fir_tlast (tlast),
        .s_axis_fir_tready(tready),
        .release_buf      (release_buf),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .frame_done       (frame_done),
        .frame_len        (frame_len),
        .len_err          (len_err),
        .peak_abs         (peak_abs),
        .frame_count      (frame_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [FL];
    int m_cnt, m_len, m_peak, m_fcount;
    bit m_hold, m_err, m_done;

    function automatic int mag(logic [DW-1:0] d);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [DW-1:0] d, bit v, bit last);
        bit acc;
        tdata  = d;
        tvalid = v;
        tlast  = last;
        chk("tready_pre", 32'(tready), 32'(!m_hold));
        acc = v && !m_hold;
        tick();
        m_done = 1'b0;
        if (acc) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (mag(d) > m_peak) m_peak = mag(d);
            if (last || m_cnt == FL) begin
                m_len    = m_cnt;
                m_err    = !(last && m_cnt == FL);
                m_fcount = (m_fcount + 1) % 65536;
                m_done   = 1'b1;
                m_hold   = 1'b1;
            end
        end
        chk("frame_done", 32'(frame_done), 32'(m_done));
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic status(string tag);
        chk({tag, "_len"},    32'(frame_len),   32'(m_len));
        chk({tag, "_err"},    32'(len_err),     32'(m_err));
        chk({tag, "_peak"},   32'(peak_abs),    32'(m_peak));
        chk({tag, "_count"},  32'(frame_count), 32'(m_fcount));
        chk({tag, "_tready"}, 32'(tready),      32'(!m_hold));
    endtask

    task automatic rd(int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), (a < FL) ? 32'(m_mem[a]) : 32'd0);
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    endtask

    task automatic rel();
        release_buf = 1'b1;
        tick();
        release_buf = 1'b0;
        if (m_hold) begin
            m_hold = 1'b0;
            m_cnt  = 0;
            m_len  = 0;
            m_peak = 0;
            m_err  = 1'b0;
        end
        chk("rel_done", 32'(frame_done), 32'd0);
    endtask

    task automatic do_reset();
        tvalid      = 1'b0;
        tlast       = 1'b0;
        rd_en       = 1'b0;
        release_buf = 1'b0;
        reset       = 1'b0;
        #2;
        chk("rst_tready", 32'(tready),      32'd1);
        chk("rst_rdata",  32'(rd_data),     32'd0);
        chk("rst_rvalid", 32'(rd_valid),    32'd0);
        chk("rst_done",   32'(frame_done),  32'd0);
        chk("rst_len",    32'(frame_len),   32'd0);
        chk("rst_err",    32'(len_err),     32'd0);
        chk("rst_peak",   32'(peak_abs),    32'd0);
        chk("rst_count",  32'(frame_count), 32'd0);
        m_cnt = 0; m_len = 0; m_peak = 0; m_fcount = 0;
        m_hold = 1'b0; m_err = 1'b0; m_done = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [DW-1:0] old;
        int k;
        bit v;
        bit rel_done_fill;
        tdata = '0;
        rd_addr = '0;
        do_reset();

        // Nominal ramp frame
        for (int i = 0; i < FL; i++) send(DW'(i), 1'b1, i == FL - 1);
        status("nom");
        chk("nom_len_c",   32'(frame_len),   32'd2048);
        chk("nom_peak_c",  32'(peak_abs),    32'd2047);
        chk("nom_count_c", 32'(frame_count), 32'd1);
        rd(0);
        rd(1000);
        rd(2047);
        send(16'h1234, 1'b1, 1'b0);
        status("nom_hold");
        rel();

        // Short frame, with a same-address read each beat to check read-first
        for (int i = 0; i < 100; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            old     = m_mem[i];
            send(DW'($urandom), 1'b1, i == 99);
            chk("rd_first", 32'(rd_data), 32'(old));
            chk("rd_first_v", 32'(rd_valid), 32'd1);
        end
        rd_en = 1'b0;
        status("short");
        chk("short_len_c", 32'(frame_len), 32'd100);
        chk("short_err_c", 32'(len_err), 32'd1);
        rd($urandom_range(0, 99));
        rel();
        status("short_rel");
        chk("short_rel_err", 32'(len_err), 32'd0);

        // Long frame: tlast never asserted, extra beat must be refused
        for (int i = 0; i < FL; i++) send(DW'($urandom), 1'b1, 1'b0);
        send(DW'($urandom), 1'b1, 1'b0);
        status("long");
        chk("long_err_c", 32'(len_err), 32'd1);
        rd(2047);
        rel();

        // Peak saturation
        send(16'h8000, 1'b1, 1'b0);
        send(16'h7FFF, 1'b1, 1'b0);
        send(16'hFFFE, 1'b1, 1'b1);
        status("peak");
        chk("peak_c", 32'(peak_abs), 32'h7FFF);
        rel();
        send(16'hFFFE, 1'b1, 1'b1);
        status("peak2");
        chk("peak2_c", 32'(peak_abs), 32'd2);
        rel();

        // Backpressure gaps, with a release pulse during FILL
        k = 0;
        rel_done_fill = 1'b0;
        while (k < 300) begin
            if (k == 150 && !rel_done_fill) begin
                rel();
                rel_done_fill = 1'b1;
            end
            v = 1'($urandom_range(0, 1));
            send(DW'($urandom), v, v && (k == 299));
            if (v) k++;
        end
        status("gap");
        chk("gap_len_c", 32'(frame_len), 32'd300);
        rd(0);
        rd(299);
        for (int i = 0; i < 20; i++) rd($urandom_range(0, 299));
        rel();

        // Reset mid-frame
        for (int i = 0; i < 500; i++) send(DW'($urandom), 1'b1, 1'b0);
        do_reset();
        status("midrst");
        for (int i = 0; i < FL; i++) send(DW'($urandom), 1'b1, i == FL - 1);
        status("after_rst");
        chk("after_len_c",   32'(frame_len),   32'd2048);
        chk("after_count_c", 32'(frame_count), 32'd1);
        rd(0);
        rd(1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
